// File: rtl/rename_stage_if.sv
// rename_stage_if: decode3-to-rename, rename-to-dispatch and ROB commit signals.
// master drives the stage inputs; slave is the rename stage itself.
`default_nettype none
interface rename_stage_if #(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64,
  parameter int PAYLOAD_W = 160
);
  localparam int AW = $clog2(ARCH_REGS);
  localparam int PW = $clog2(PHYS_REGS);

  logic                 in_valid;
  logic                 in_ready;
  logic [AW-1:0]        in_rs1_arch, in_rs2_arch, in_rs3_arch;
  logic                 in_rs1_valid, in_rs2_valid, in_rs3_valid;
  logic                 in_rs1_pred, in_rs2_pred, in_rs3_pred;
  logic [AW-1:0]        in_rd_arch;
  logic                 in_rd_valid;
  logic [PAYLOAD_W-1:0] in_payload;

  logic                 out_valid;
  logic                 out_ready;
  logic [PW-1:0]        out_rs1_phys, out_rs2_phys, out_rs3_phys;
  logic                 out_rs1_valid, out_rs2_valid, out_rs3_valid;
  logic                 out_rs1_pred, out_rs2_pred, out_rs3_pred;
  logic [PW-1:0]        out_rd_phys, out_rd_old_phys;
  logic                 out_rd_valid;
  logic [PAYLOAD_W-1:0] out_payload;

  logic                 commit_valid;
  logic [AW-1:0]        commit_rd_arch;
  logic [PW-1:0]        commit_rd_phys, commit_old_phys;

  modport master (
    output in_valid, in_rs1_arch, in_rs2_arch, in_rs3_arch,
           in_rs1_valid, in_rs2_valid, in_rs3_valid,
           in_rs1_pred, in_rs2_pred, in_rs3_pred,
           in_rd_arch, in_rd_valid, in_payload, out_ready,
           commit_valid, commit_rd_arch, commit_rd_phys, commit_old_phys,
    input  in_ready, out_valid, out_rs1_phys, out_rs2_phys, out_rs3_phys,
           out_rs1_valid, out_rs2_valid, out_rs3_valid,
           out_rs1_pred, out_rs2_pred, out_rs3_pred,
           out_rd_phys, out_rd_old_phys, out_rd_valid, out_payload
  );

  modport slave (
    input  in_valid, in_rs1_arch, in_rs2_arch, in_rs3_arch,
           in_rs1_valid, in_rs2_valid, in_rs3_valid,
           in_rs1_pred, in_rs2_pred, in_rs3_pred,
           in_rd_arch, in_rd_valid, in_payload, out_ready,
           commit_valid, commit_rd_arch, commit_rd_phys, commit_old_phys,
    output in_ready, out_valid, out_rs1_phys, out_rs2_phys, out_rs3_phys,
           out_rs1_valid, out_rs2_valid, out_rs3_valid,
           out_rs1_pred, out_rs2_pred, out_rs3_pred,
           out_rd_phys, out_rd_old_phys, out_rd_valid, out_payload
  );
endinterface
`default_nettype wire

// File: rtl/rename_stage.sv
// rename_stage: speculative/retirement RATs and circular free list; flush restores committed state.
// Optional macro RNS_PERF_CNT_EN adds a saturating empty-free-list stall counter.
`default_nettype none
module rename_stage #(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64,
  parameter int PAYLOAD_W = 160
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clk_en_i,
  input  logic          flush_valid_i,
  rename_stage_if.slave rn,
  output logic [31:0]   perf_empty_stalls_o
);
  localparam int AW        = $clog2(ARCH_REGS);
  localparam int PW        = $clog2(PHYS_REGS);
  localparam int FREE_INIT = PHYS_REGS - ARCH_REGS;
  localparam logic [PW:0] PTR_ONE = 1;

  logic [PW-1:0] spec_rat_q   [ARCH_REGS];
  logic [PW-1:0] retire_rat_q [ARCH_REGS];
  logic [PW-1:0] free_q       [PHYS_REGS];
  logic [PW:0]   head_q, tail_q, commit_head_q;
  logic [PW:0]   count;
  logic          need_alloc, accept, commit_fire, commit_rat_wr;

  logic [AW-1:0] rs_arch [3];
  logic [2:0]    rs_valid, rs_pred, rs_use;
  logic [PW-1:0] rs_phys_d [3];
  logic [PW-1:0] rd_phys_d, rd_old_d;

  logic                 out_valid_q, rd_valid_q;
  logic [PW-1:0]        rs_phys_q [3];
  logic [2:0]           rs_valid_q, rs_pred_q;
  logic [PW-1:0]        rd_phys_q, rd_old_q;
  logic [PAYLOAD_W-1:0] payload_q;

  assign rs_arch[0] = rn.in_rs1_arch;
  assign rs_arch[1] = rn.in_rs2_arch;
  assign rs_arch[2] = rn.in_rs3_arch;
  assign rs_valid   = {rn.in_rs3_valid, rn.in_rs2_valid, rn.in_rs1_valid};
  assign rs_pred    = {rn.in_rs3_pred, rn.in_rs2_pred, rn.in_rs1_pred};
  assign rs_use     = rs_valid & ~rs_pred;

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  assign need_alloc    = rn.in_rd_valid && (rn.in_rd_arch != '0);
  assign count         = tail_q - head_q;
  assign rn.in_ready   = rst_ni && clk_en_i && !flush_valid_i &&
                         (!out_valid_q || rn.out_ready) && (!need_alloc || count != '0);
  assign accept        = rn.in_valid && rn.in_ready;
  assign commit_fire   = clk_en_i && rn.commit_valid;
  assign commit_rat_wr = commit_fire && (rn.commit_rd_arch != '0);

  // Lookups use the table before this instruction's own rd update.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      rs_phys_d[k] = rs_use[k] ? spec_rat_q[rs_arch[k]] : '0;
    end
    rd_phys_d = need_alloc ? free_q[head_q[PW-1:0]] : '0;
    rd_old_d  = need_alloc ? spec_rat_q[rn.in_rd_arch] : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        spec_rat_q[i]   <= PW'(i);
        retire_rat_q[i] <= PW'(i);
      end
      for (int i = 0; i < PHYS_REGS; i++) begin
        free_q[i] <= (i < FREE_INIT) ? PW'(ARCH_REGS + i) : '0;
      end
      head_q        <= '0;
      commit_head_q <= '0;
      tail_q        <= (PW+1)'(FREE_INIT);
    end else if (clk_en_i) begin
      if (commit_fire) begin
        if (commit_rat_wr) retire_rat_q[rn.commit_rd_arch] <= rn.commit_rd_phys;
        free_q[tail_q[PW-1:0]] <= rn.commit_old_phys;
        tail_q                 <= tail_q + PTR_ONE;
        commit_head_q          <= commit_head_q + PTR_ONE;
      end
      // Flush folds in any same-cycle commit so the restored state is current.
      if (flush_valid_i) begin
        for (int i = 0; i < ARCH_REGS; i++) begin
          spec_rat_q[i] <= (commit_rat_wr && rn.commit_rd_arch == AW'(i)) ?
                           rn.commit_rd_phys : retire_rat_q[i];
        end
        head_q <= commit_fire ? commit_head_q + PTR_ONE : commit_head_q;
      end else if (accept && need_alloc) begin
        spec_rat_q[rn.in_rd_arch] <= rd_phys_d;
        head_q                    <= head_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      for (int k = 0; k < 3; k++) rs_phys_q[k] <= '0;
      rs_valid_q  <= '0;
      rs_pred_q   <= '0;
      rd_phys_q   <= '0;
      rd_old_q    <= '0;
      rd_valid_q  <= 1'b0;
      payload_q   <= '0;
    end else if (clk_en_i) begin
      if (flush_valid_i) begin
        out_valid_q <= 1'b0;
      end else if (accept) begin
        out_valid_q <= 1'b1;
        for (int k = 0; k < 3; k++) rs_phys_q[k] <= rs_phys_d[k];
        rs_valid_q  <= rs_valid;
        rs_pred_q   <= rs_pred;
        rd_phys_q   <= rd_phys_d;
        rd_old_q    <= rd_old_d;
        rd_valid_q  <= need_alloc;
        payload_q   <= rn.in_payload;
      end else if (rn.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign rn.out_valid       = out_valid_q;
  assign rn.out_rs1_phys    = rs_phys_q[0];
  assign rn.out_rs2_phys    = rs_phys_q[1];
  assign rn.out_rs3_phys    = rs_phys_q[2];
  assign rn.out_rs1_valid   = rs_valid_q[0];
  assign rn.out_rs2_valid   = rs_valid_q[1];
  assign rn.out_rs3_valid   = rs_valid_q[2];
  assign rn.out_rs1_pred    = rs_pred_q[0];
  assign rn.out_rs2_pred    = rs_pred_q[1];
  assign rn.out_rs3_pred    = rs_pred_q[2];
  assign rn.out_rd_phys     = rd_phys_q;
  assign rn.out_rd_old_phys = rd_old_q;
  assign rn.out_rd_valid    = rd_valid_q;
  assign rn.out_payload     = payload_q;

`ifdef RNS_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_q <= '0;
    end else if (clk_en_i) begin
      if (flush_valid_i) begin
        perf_q <= '0;
      end else if (rn.in_valid && need_alloc && count == '0 && perf_q != '1) begin
        perf_q <= perf_q + 32'd1;
      end
    end
  end

  assign perf_empty_stalls_o = perf_q;
`else
  assign perf_empty_stalls_o = '0;
`endif
endmodule
`default_nettype wire
